// File: rtl/sal_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sal_cmd_pkg
// Description : DFI command encodings and per-command pin patterns shared by
//               the command arbiter and its timers.
// Revision    : 1.0 - initial release
// ============================================================================
package sal_cmd_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_t;

    typedef struct packed {
        logic ras_n;
        logic cas_n;
        logic we_n;
        logic odt;
    } pins_t;

    localparam pins_t c_PINS_NOP = 4'b1110;
    localparam pins_t c_PINS_ACT = 4'b0110;
    localparam pins_t c_PINS_RD  = 4'b1010;
    localparam pins_t c_PINS_WR  = 4'b1001;
    localparam pins_t c_PINS_PRE = 4'b0100;
    localparam pins_t c_PINS_REF = 4'b0010;

    localparam int c_NUM_FAW = 4;

    function automatic pins_t cmd_pins(input logic [2:0] cmd);
        pins_t p;
        case (cmd)
            CMD_ACT: p = c_PINS_ACT;
            CMD_RD:  p = c_PINS_RD;
            CMD_WR:  p = c_PINS_WR;
            CMD_PRE: p = c_PINS_PRE;
            CMD_REF: p = c_PINS_REF;
            default: p = c_PINS_NOP;
        endcase
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sal_cmd_timer.sv
`default_nettype none
// ============================================================================
// Module      : sal_cmd_timer
// Description : Loadable down-counter; loads t_i-1 (floored at 0) and counts
//               to zero, so back-to-back events are spaced max(t_i,1) cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module sal_cmd_timer #(
    parameter int TW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [TW-1:0] t_i,
    output logic          is_zero_o
);

    logic [TW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= (t_i == '0) ? '0 : t_i - 1'b1;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign is_zero_o = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sal_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sal_cmd_arbiter
// Description : Round-robin arbiter sharing one DFI command bus among the
//               per-bank controllers, enforcing tRRD/tFAW/tCCD/tWTR.
// Revision    : 1.0 - initial release
// ============================================================================
module sal_cmd_arbiter
    import sal_cmd_pkg::*;
#(
    parameter int NUM_BANKS  = 4,
    parameter int BA_WIDTH   = 2,
    parameter int ADDR_WIDTH = 14,
    parameter int TW         = 6
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_BANKS-1:0]            req_valid_i,
    input  logic [NUM_BANKS*3-1:0]          req_cmd_i,
    input  logic [NUM_BANKS*ADDR_WIDTH-1:0] req_addr_i,
    output logic [NUM_BANKS-1:0]            req_gnt_o,
    input  logic [TW-1:0]                   t_rrd_i,
    input  logic [TW-1:0]                   t_faw_i,
    input  logic [TW-1:0]                   t_ccd_i,
    input  logic [TW-1:0]                   t_wtr_i,
    output logic                            dfi_cke_o,
    output logic                            dfi_cs_n_o,
    output logic                            dfi_ras_n_o,
    output logic                            dfi_cas_n_o,
    output logic                            dfi_we_n_o,
    output logic [BA_WIDTH-1:0]             dfi_ba_o,
    output logic [ADDR_WIDTH-1:0]           dfi_addr_o,
    output logic                            dfi_odt_o
);

    logic [2:0]            w_cmd  [NUM_BANKS];
    logic [ADDR_WIDTH-1:0] w_addr [NUM_BANKS];
    logic [NUM_BANKS-1:0]  w_elig;
    logic [NUM_BANKS-1:0]  w_req_ok;
    logic [BA_WIDTH-1:0]   r_rr_ptr;
    logic [BA_WIDTH-1:0]   w_gnt_idx;
    logic                  w_any;
    int                    w_scan_idx;

    logic                  w_rrd_zero, w_ccd_zero, w_wtr_zero;
    logic [c_NUM_FAW-1:0]  w_faw_zero, w_faw_load;
    logic                  w_faw_found;

    logic [2:0]            w_sel_cmd;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic                  w_gnt_act, w_gnt_col, w_gnt_wr;

    logic                  w_nxt_cs_n;
    pins_t                 w_nxt_pins;
    logic [BA_WIDTH-1:0]   w_nxt_ba;
    logic [ADDR_WIDTH-1:0] w_nxt_addr;
    logic                  r_cs_n;
    pins_t                 r_pins;
    logic [BA_WIDTH-1:0]   r_ba;
    logic [ADDR_WIDTH-1:0] r_addr;

    generate
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
            assign w_cmd[b]  = req_cmd_i[b*3 +: 3];
            assign w_addr[b] = req_addr_i[b*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    always_comb begin
        w_elig = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            case (w_cmd[b])
                CMD_ACT: w_elig[b] = w_rrd_zero & (|w_faw_zero);
                CMD_RD:  w_elig[b] = w_ccd_zero & w_wtr_zero;
                CMD_WR:  w_elig[b] = w_ccd_zero;
                CMD_PRE: w_elig[b] = 1'b1;
                CMD_REF: w_elig[b] = 1'b1;
                default: w_elig[b] = 1'b0;
            endcase
        end
    end

    // Grants are suppressed while reset is held, even though requests may stay up.
    assign w_req_ok = req_valid_i & w_elig & {NUM_BANKS{~rst}};

    always_comb begin
        w_any      = 1'b0;
        w_gnt_idx  = '0;
        w_scan_idx = 0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            w_scan_idx = int'(r_rr_ptr) + i;
            if (w_scan_idx >= NUM_BANKS) begin
                w_scan_idx = w_scan_idx - NUM_BANKS;
            end
            if (!w_any && w_req_ok[w_scan_idx]) begin
                w_any     = 1'b1;
                w_gnt_idx = w_scan_idx[BA_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        req_gnt_o = '0;
        if (w_any) begin
            req_gnt_o[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_any) begin
            r_rr_ptr <= (w_gnt_idx == BA_WIDTH'(NUM_BANKS - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    assign w_sel_cmd  = w_cmd[w_gnt_idx];
    assign w_sel_addr = w_addr[w_gnt_idx];
    assign w_gnt_act  = w_any & (w_sel_cmd == CMD_ACT);
    assign w_gnt_col  = w_any & ((w_sel_cmd == CMD_RD) | (w_sel_cmd == CMD_WR));
    assign w_gnt_wr   = w_any & (w_sel_cmd == CMD_WR);

    sal_cmd_timer #(.TW(TW)) u_rrd (
        .clk(clk), .rst(rst), .load_i(w_gnt_act), .t_i(t_rrd_i), .is_zero_o(w_rrd_zero)
    );
    sal_cmd_timer #(.TW(TW)) u_ccd (
        .clk(clk), .rst(rst), .load_i(w_gnt_col), .t_i(t_ccd_i), .is_zero_o(w_ccd_zero)
    );
    sal_cmd_timer #(.TW(TW)) u_wtr (
        .clk(clk), .rst(rst), .load_i(w_gnt_wr), .t_i(t_wtr_i), .is_zero_o(w_wtr_zero)
    );

    // Each ACT claims the lowest free slot; a full set of busy slots blocks ACT.
    always_comb begin
        w_faw_load  = '0;
        w_faw_found = 1'b0;
        for (int s = 0; s < c_NUM_FAW; s++) begin
            if (w_faw_zero[s] && !w_faw_found) begin
                w_faw_load[s] = w_gnt_act;
                w_faw_found   = 1'b1;
            end
        end
    end

    generate
        for (genvar s = 0; s < c_NUM_FAW; s++) begin : g_faw
            sal_cmd_timer #(.TW(TW)) u_faw (
                .clk(clk), .rst(rst), .load_i(w_faw_load[s]), .t_i(t_faw_i),
                .is_zero_o(w_faw_zero[s])
            );
        end
    endgenerate

    always_comb begin
        w_nxt_cs_n = 1'b1;
        w_nxt_pins = c_PINS_NOP;
        w_nxt_ba   = '0;
        w_nxt_addr = '0;
        if (w_any) begin
            w_nxt_cs_n = 1'b0;
            w_nxt_pins = cmd_pins(w_sel_cmd);
            w_nxt_ba   = w_gnt_idx;
            w_nxt_addr = w_sel_addr;
            if (w_sel_cmd == CMD_PRE) begin
                w_nxt_addr[10] = 1'b0;
            end else if (w_sel_cmd == CMD_REF) begin
                w_nxt_ba   = '0;
                w_nxt_addr = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_n <= 1'b1;
            r_pins <= c_PINS_NOP;
            r_ba   <= '0;
            r_addr <= '0;
        end else begin
            r_cs_n <= w_nxt_cs_n;
            r_pins <= w_nxt_pins;
            r_ba   <= w_nxt_ba;
            r_addr <= w_nxt_addr;
        end
    end

    assign dfi_cke_o   = 1'b1;
    assign dfi_cs_n_o  = r_cs_n;
    assign dfi_ras_n_o = r_pins.ras_n;
    assign dfi_cas_n_o = r_pins.cas_n;
    assign dfi_we_n_o  = r_pins.we_n;
    assign dfi_odt_o   = r_pins.odt;
    assign dfi_ba_o    = r_ba;
    assign dfi_addr_o  = r_addr;

endmodule
`default_nettype wire
